// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared FSM state and read-latency constants for sram_1rw_clr
package sram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } sram_state_e;

  localparam int READ_LATENCY_1 = 1;
  localparam int READ_LATENCY_2 = 2;

endpackage

// File: rtl/sram_1rw_clr_array.sv
// rtl/sram_1rw_clr_array.sv - masked-write storage with a 1-cycle registered read
module sram_1rw_clr_array #(
  parameter int BITS       = 32,
  parameter int WORD_DEPTH = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  ce_in,
  input  logic                  we_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [BITS-1:0]       wd_in,
  input  logic [BITS-1:0]       w_mask_in,
  output logic [BITS-1:0]       rd_out
);

  logic [BITS-1:0] mem [WORD_DEPTH];
  logic            in_range;

  // Extra bit so the compare holds when WORD_DEPTH == 2**ADDR_WIDTH.
  assign in_range = ({1'b0, addr_in} < (ADDR_WIDTH + 1)'(WORD_DEPTH));

  always_ff @(posedge clk) begin
    if (ce_in && we_in && in_range) begin
      mem[addr_in] <= (mem[addr_in] & ~w_mask_in) | (wd_in & w_mask_in);
    end
    if (ce_in && !we_in) begin
      rd_out <= in_range ? mem[addr_in] : '0;
    end
  end

endmodule

// File: rtl/sram_1rw_clr.sv
// rtl/sram_1rw_clr.sv - single-port SRAM with post-reset zero fill and 1/2-cycle read latency
module sram_1rw_clr
  import sram_pkg::*;
#(
  parameter int BITS           = 32,
  parameter int WORD_DEPTH     = 64,
  parameter int ADDR_WIDTH     = 6,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce_in,
  input  logic                  we_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [BITS-1:0]       wd_in,
  input  logic [BITS-1:0]       w_mask_in,
  output logic [BITS-1:0]       rd_out,
  output logic                  rd_valid_out,
  output logic                  busy_out
);

  sram_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_ptr;
  logic                  last_clr;
  logic                  busy;
  logic                  rd_req;
  logic                  s1_valid;

  logic                  arr_ce, arr_we;
  logic [ADDR_WIDTH-1:0] arr_addr;
  logic [BITS-1:0]       arr_wd, arr_mask, arr_rd;

  assign busy     = (state_q == CLEAR);
  assign busy_out = busy;
  assign last_clr = (clr_ptr == ADDR_WIDTH'(WORD_DEPTH - 1));
  assign rd_req   = !reset && !busy && ce_in && !we_in;

  always_comb begin
    state_d = state_q;
    if (state_q == CLEAR && last_clr) begin
      state_d = READY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      clr_ptr  <= '0;
      s1_valid <= 1'b0;
    end else begin
      state_q  <= state_d;
      s1_valid <= rd_req;
      if (busy && !last_clr) begin
        clr_ptr <= clr_ptr + 1'b1;
      end
    end
  end

  // The clear sequencer owns the array port; user requests are dropped while busy.
  always_comb begin
    arr_ce   = 1'b0;
    arr_we   = 1'b0;
    arr_addr = addr_in;
    arr_wd   = wd_in;
    arr_mask = w_mask_in;
    if (!reset) begin
      if (busy) begin
        arr_ce   = 1'b1;
        arr_we   = 1'b1;
        arr_addr = clr_ptr;
        arr_wd   = '0;
        arr_mask = '1;
      end else begin
        arr_ce   = ce_in;
        arr_we   = we_in;
      end
    end
  end

  sram_1rw_clr_array #(
    .BITS       (BITS),
    .WORD_DEPTH (WORD_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk       (clk),
    .ce_in     (arr_ce),
    .we_in     (arr_we),
    .addr_in   (arr_addr),
    .wd_in     (arr_wd),
    .w_mask_in (arr_mask),
    .rd_out    (arr_rd)
  );

  generate
    if (READ_LATENCY == READ_LATENCY_2) begin : g_lat2
      logic [BITS-1:0] rd_q2;
      logic            s2_valid;

      always_ff @(posedge clk) begin
        if (reset) begin
          rd_q2    <= '0;
          s2_valid <= 1'b0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) begin
            rd_q2 <= arr_rd;
          end
        end
      end

      assign rd_out       = rd_q2;
      assign rd_valid_out = s2_valid;
    end else begin : g_lat1
      // The array read register is not reset, so a shadow copy supplies the reset/hold value.
      logic [BITS-1:0] rd_last;

      always_ff @(posedge clk) begin
        if (reset) begin
          rd_last <= '0;
        end else if (s1_valid) begin
          rd_last <= arr_rd;
        end
      end

      assign rd_out       = s1_valid ? arr_rd : rd_last;
      assign rd_valid_out = s1_valid;
    end
  endgenerate

endmodule

// File: tb/tb_sram_1rw_clr.sv
// tb/tb_sram_1rw_clr.sv - scoreboard bench for sram_1rw_clr across three parameter sets
module tb_sram_1rw_clr;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce   [3];
  logic        we   [3];
  logic [5:0]  addr [3];
  logic [31:0] wd   [3];
  logic [31:0] mask [3];
  logic [31:0] rd   [3];
  logic        rv   [3];
  logic        busy [3];

  int          lat [3] = '{1, 2, 1};
  logic [31:0] exp_d [3][$];
  int          exp_t [3][$];
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  sram_1rw_clr u0 (
    .clk(clk), .reset(reset), .ce_in(ce[0]), .we_in(we[0]), .addr_in(addr[0]),
    .wd_in(wd[0]), .w_mask_in(mask[0]), .rd_out(rd[0]), .rd_valid_out(rv[0]),
    .busy_out(busy[0])
  );

  sram_1rw_clr #(.READ_LATENCY(2)) u1 (
    .clk(clk), .reset(reset), .ce_in(ce[1]), .we_in(we[1]), .addr_in(addr[1]),
    .wd_in(wd[1]), .w_mask_in(mask[1]), .rd_out(rd[1]), .rd_valid_out(rv[1]),
    .busy_out(busy[1])
  );

  sram_1rw_clr #(.WORD_DEPTH(48), .ADDR_WIDTH(6)) u2 (
    .clk(clk), .reset(reset), .ce_in(ce[2]), .we_in(we[2]), .addr_in(addr[2]),
    .wd_in(wd[2]), .w_mask_in(mask[2]), .rd_out(rd[2]), .rd_valid_out(rv[2]),
    .busy_out(busy[2])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic op_wr(input int i, input int a, input logic [31:0] d, input logic [31:0] m);
    @(negedge clk);
    ce[i] = 1'b1; we[i] = 1'b1; addr[i] = 6'(a); wd[i] = d; mask[i] = m;
  endtask

  task automatic op_rd(input int i, input int a, input logic [31:0] expv);
    @(negedge clk);
    ce[i] = 1'b1; we[i] = 1'b0; addr[i] = 6'(a);
    exp_d[i].push_back(expv);
    exp_t[i].push_back(cyc + lat[i]);
  endtask

  task automatic op_idle(input int i);
    @(negedge clk);
    ce[i] = 1'b0; we[i] = 1'b0;
  endtask

  // Count busy cycles starting at the current negedge until all instances are ready.
  task automatic count_busy(output int n0, output int n1, output int n2);
    n0 = 0; n1 = 0; n2 = 0;
    for (int c = 0; c < 200; c++) begin
      if (busy[0]) n0++;
      if (busy[1]) n1++;
      if (busy[2]) n2++;
      if (!busy[0] && !busy[1] && !busy[2]) break;
      @(negedge clk);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rv[i] === 1'b1) begin
        if (exp_d[i].size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_valid u%0d: rd_out=%h, no read outstanding (cycle %0d)", i, rd[i], cyc);
        end else begin
          chk($sformatf("rd_data_u%0d", i), rd[i], exp_d[i].pop_front());
          chk($sformatf("rd_time_u%0d", i), 32'(cyc), 32'(exp_t[i].pop_front()));
        end
      end else if (exp_t[i].size() != 0 && exp_t[i][0] < cyc) begin
        vectors++;
        miscompares++;
        $display("FAIL missing_valid u%0d: no pulse, required at cycle %0d (now %0d)", i, exp_t[i][0], cyc);
        void'(exp_d[i].pop_front());
        void'(exp_t[i].pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n1, n2;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ce[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wd[i] = '0; mask[i] = '0;
    end

    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_rd_u%0d", i), rd[i], 32'h0);
      chk($sformatf("reset_valid_u%0d", i), 32'(rv[i]), 32'h0);
      chk($sformatf("reset_busy_u%0d", i), 32'(busy[i]), 32'h1);
    end

    // Requests held throughout the clear must be dropped.
    ce[0] = 1'b1; we[0] = 1'b1; addr[0] = 6'd7; wd[0] = 32'h0000DEAD; mask[0] = '1;
    ce[1] = 1'b1; we[1] = 1'b0; addr[1] = 6'd3;
    reset = 1'b0;
    count_busy(n0, n1, n2);
    ce[0] = 1'b0; we[0] = 1'b0; ce[1] = 1'b0;
    chk("clear_cycles_u0", 32'(n0), 32'd64);
    chk("clear_cycles_u1", 32'(n1), 32'd64);
    chk("clear_cycles_u2", 32'(n2), 32'd48);

    op_rd(0, 63, 32'h0);
    op_rd(0, 7, 32'h0);
    op_idle(0);

    op_wr(0, 5, 32'hFFFFFFFF, 32'hFFFFFFFF);
    op_wr(0, 5, 32'h00000000, 32'h0000FF00);
    op_rd(0, 5, 32'hFFFF00FF);
    op_idle(0);
    repeat (3) @(negedge clk);
    chk("hold_rd_u0", rd[0], 32'hFFFF00FF);
    op_wr(0, 5, 32'h12345678, 32'hFFFFFFFF);
    op_idle(0);
    @(negedge clk);
    chk("write_keeps_rd_u0", rd[0], 32'hFFFF00FF);
    op_rd(0, 5, 32'h12345678);
    op_wr(0, 9, 32'hA5A5A5A5, 32'hFFFFFFFF);
    op_wr(0, 9, 32'hFFFFFFFF, 32'hF0F0F0F0);
    @(negedge clk);
    ce[0] = 1'b0; we[0] = 1'b1; addr[0] = 6'd9; wd[0] = 32'h0; mask[0] = '1;
    op_rd(0, 9, 32'hF5F5F5F5);
    op_idle(0);

    op_wr(1, 1, 32'h11, 32'hFFFFFFFF);
    op_wr(1, 2, 32'h22, 32'hFFFFFFFF);
    op_wr(1, 3, 32'h33, 32'hFFFFFFFF);
    op_rd(1, 1, 32'h11);
    op_rd(1, 2, 32'h22);
    op_rd(1, 3, 32'h33);
    op_idle(1);

    op_wr(2, 47, 32'h0000AAAA, 32'hFFFFFFFF);
    op_wr(2, 18, 32'h00005555, 32'hFFFFFFFF);
    op_wr(2, 50, 32'h00001234, 32'hFFFFFFFF);
    op_rd(2, 50, 32'h0);
    op_rd(2, 47, 32'h0000AAAA);
    op_rd(2, 18, 32'h00005555);
    op_idle(2);
    repeat (4) @(negedge clk);

    // Reads in flight when reset hits must vanish.
    @(negedge clk);
    ce[1] = 1'b1; we[1] = 1'b0; addr[1] = 6'd1;
    @(negedge clk);
    ce[1] = 1'b0;
    ce[0] = 1'b1; we[0] = 1'b0; addr[0] = 6'd5;
    reset = 1'b1;
    @(negedge clk);
    ce[0] = 1'b0;
    chk("reset_clears_rd_u0", rd[0], 32'h0);
    chk("reset_clears_rd_u1", rd[1], 32'h0);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("busy_mid_clear_u0", 32'(busy[0]), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    count_busy(n0, n1, n2);
    chk("reclear_cycles_u0", 32'(n0), 32'd64);
    chk("reclear_cycles_u1", 32'(n1), 32'd64);
    chk("reclear_cycles_u2", 32'(n2), 32'd48);
    op_rd(0, 5, 32'h0);
    op_idle(0);
    repeat (4) @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      chk($sformatf("drained_u%0d", i), 32'(exp_d[i].size()), 32'h0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_1rw_clr.md
SRAM_1RW_CLR -- requirements
Module: sram_1rw_clr

Interface
REQ-001 SHALL have parameter BITS, default 32, data word width.
REQ-002 SHALL have parameter WORD_DEPTH, default 64, number of words.
REQ-003 SHALL have parameter ADDR_WIDTH, default 6, address width; SHALL be >= clog2(WORD_DEPTH).
REQ-004 SHALL have parameter READ_LATENCY, default 1, read latency; legal values are 1 and 2.
REQ-005 SHALL have parameter CLEAR_ON_RESET, default 1; 1 zero-fills the array after reset.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit, reset; it is synchronous and active-high.
REQ-008 SHALL have port ce_in, input, 1 bit, access enable.
REQ-009 SHALL have port we_in, input, 1 bit, write when 1 and read when 0; qualified by ce_in.
REQ-010 SHALL have port addr_in, input, ADDR_WIDTH bits, word address.
REQ-011 SHALL have port wd_in, input, BITS bits, write data.
REQ-012 SHALL have port w_mask_in, input, BITS bits, per-bit write enable.
REQ-013 SHALL have port rd_out, output, BITS bits, read data.
REQ-014 SHALL have port rd_valid_out, output, 1 bit, one-cycle pulse marking new rd_out.
REQ-015 SHALL have port busy_out, output, 1 bit, high while clearing; requests are ignored while it is high.

Function
REQ-016 FSM states SHALL be CLEAR and READY; reset enters CLEAR if CLEAR_ON_RESET=1, else READY.
REQ-017 In CLEAR the block SHALL write all-zero to address clr_ptr each cycle, with clr_ptr running 0..WORD_DEPTH-1; after the write to WORD_DEPTH-1 it SHALL enter READY on the next cycle.
REQ-018 The clear sequence SHALL take exactly WORD_DEPTH cycles.
REQ-019 busy_out SHALL be 1 exactly in CLEAR, and the block SHALL drop ce_in accesses there (no write, no rd_valid_out).
REQ-020 In READY, ce_in=1 and we_in=1 SHALL set mem[addr] = (mem[addr] & ~w_mask_in) | (wd_in & w_mask_in).
REQ-021 A write SHALL leave rd_out unchanged and SHALL not assert rd_valid_out.
REQ-022 In READY, ce_in=1 and we_in=0 SHALL present mem[addr] on rd_out with rd_valid_out=1 exactly READ_LATENCY cycles after the request edge.
REQ-023 Back-to-back reads SHALL be accepted every cycle, fully pipelined, with results returned in order.
REQ-024 A read issued the cycle after a write to the same address SHALL return the newly written data.
REQ-025 A write with addr_in >= WORD_DEPTH SHALL be ignored.
REQ-026 A read with addr_in >= WORD_DEPTH SHALL return all-zero, still with rd_valid_out.
REQ-027 rd_out SHALL hold its last value whenever rd_valid_out=0.
REQ-028 ce_in=0 SHALL cause no state change.
REQ-029 With READ_LATENCY=2, the stage-2 register SHALL update only when stage-1 holds a valid read.

Reset
REQ-030 On reset, rd_out SHALL become 0, rd_valid_out 0, all pipeline valids 0, and clr_ptr 0.
REQ-031 On reset, busy_out SHALL become CLEAR_ON_RESET.
REQ-032 Reset asserted mid-clear SHALL restart the clear sequence at address 0.
REQ-033 Reset asserted with reads in flight SHALL discard those reads; no rd_valid_out pulse follows.
REQ-034 Array contents SHALL NOT be reset directly; only the clear sequence zeroes them.

Structure
REQ-035 Package sram_pkg SHALL hold the FSM state enum (CLEAR, READY) and the legal READ_LATENCY constants.
REQ-036 One sub-module, sram_1rw_clr_array, SHALL hold the masked-write storage and the 1-cycle registered read; the top SHALL hold the FSM, clear pointer, write-port mux and latency pipeline.
REQ-037 The sub-module port list SHALL match the top's data ports, so that a hardened macro with the same interface can replace it.

Verification
REQ-038 Clear: default params; reset 1 cycle then release -> busy_out=1 for exactly 64 cycles; a read of addr 63 in cycle 64 returns 0x00000000.
REQ-039 Masked write: write 0xFFFFFFFF at 5, then 0x00000000 with mask 0x0000FF00 at 5, read 5 -> rd_out=0xFFFF00FF one cycle later with a single rd_valid_out pulse.
REQ-040 Pipelined reads: READ_LATENCY=2; preload addrs 1,2,3 with 0x11,0x22,0x33; read 1,2,3 on consecutive cycles -> 0x11,0x22,0x33 on consecutive cycles starting 2 cycles after the first request.
REQ-041 Busy drop: write 0xDEAD at addr 7 while busy_out=1 -> after clear, read 7 returns 0.
REQ-042 Mid-clear reset: assert reset at clear cycle 30 -> busy_out stays 1 for a further 64 cycles after release; a read issued 1 cycle before reset yields no rd_valid_out.
REQ-043 Out-of-range: WORD_DEPTH=48, ADDR_WIDTH=6; write 0x1234 at addr 50, read 50 -> rd_out=0, rd_valid_out=1, and no other word changes.
